inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15: maximum cycles spent in REQ without imem_ack before a timeout error.
REQ-002 pc_clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 pc  in  32  current program counter from the PC register.
REQ-005 pc_en  out  1  PC register update enable.
REQ-006 imem_req  out  1  instruction memory read request.
REQ-007 imem_addr  out  32  word-aligned fetch address.
REQ-008 imem_ack  in  1  memory response strobe; imem_rdata valid in the same cycle.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 inst  out  32  held instruction for decode.
REQ-011 inst_pc  out  32  address that inst was fetched from.
REQ-012 inst_valid  out  1  inst is valid for decode.
REQ-013 decode_ready  in  1  decode accepts inst this cycle.
REQ-014 flush  in  1  redirect: discard the in-flight or held instruction.
REQ-015 fetch_err  out  1  sticky error flag.
REQ-016 err_cause  out  2  error cause: 01 = misaligned pc, 10 = timeout, 00 = none.

Function
REQ-017 The FSM SHALL have exactly four states: LAUNCH, REQ, HOLD, ERR.
REQ-018 LAUNCH, pc[1:0]==00:
- latch imem_addr<=pc and inst_pc<=pc;
- clear the timeout counter;
- go to REQ on the next edge.
REQ-019 LAUNCH, pc[1:0]!=00: go to ERR with err_cause<=01 and issue no request.
REQ-020 REQ: imem_req=1, with imem_addr held stable until the ack cycle inclusive.
REQ-021 REQ with imem_ack=1:
- drop flag clear: capture inst<=imem_rdata and go to HOLD;
- drop flag set: discard imem_rdata, clear the drop flag, go to LAUNCH.
REQ-022 REQ without imem_ack: increment the 4-bit saturating timeout counter. When the counter reaches TIMEOUT_CYC-1 with no ack, go to ERR with err_cause<=10 and deassert imem_req on the next cycle.
REQ-023 Flush in REQ:
- set the drop flag;
- do not drop imem_req (a request is never withdrawn before ack);
- timeout continues to apply.
REQ-024 HOLD: inst_valid=1. inst and inst_pc SHALL remain stable until consumed or flushed.
REQ-025 pc_en = (HOLD & decode_ready & ~flush) | flush, combinationally; pc_en is 0 in all other cases.
REQ-026 HOLD with decode_ready=1 and flush=0: the instruction is consumed that cycle; go to LAUNCH. The PC register advances on the same edge.
REQ-027 HOLD with flush=1: discard the instruction regardless of decode_ready; go to LAUNCH.
REQ-028 ERR:
- fetch_err=1, imem_req=0, inst_valid=0;
- stay in ERR until flush=1;
- on flush, clear fetch_err and err_cause and go to LAUNCH.
REQ-029 inst_valid SHALL be 1 only in HOLD and SHALL never be 1 for data captured while the drop flag was set.
REQ-030 Fetch round trip from LAUNCH with a zero-wait ack is 3 cycles: LAUNCH, REQ, HOLD.
REQ-031 No address arithmetic is performed here. Sequential addressing comes from the PC register's own +4 path via pc_en.

Reset
REQ-032 Reset state:
- state = LAUNCH;
- imem_req=0, imem_addr=0, inst=0, inst_pc=0, inst_valid=0;
- fetch_err=0, err_cause=00;
- drop flag = 0, timeout counter = 0.
REQ-033 Reset asserted mid-request SHALL abandon the transaction immediately. A late imem_ack after reset deassertion SHALL be ignored unless the block is in REQ.
REQ-034 pc_en SHALL be 0 while reset=1.

Verification
REQ-035 Basic fetch: reset release with pc=0x00000000 and ack one cycle after imem_req with rdata=0x3C010001 -> imem_addr=0x0, inst=0x3C010001, inst_pc=0x0, inst_valid=1. With decode_ready=1 -> pc_en=1 for one cycle; the next request is issued at 0x00000004.
REQ-036 Backpressure: decode_ready=0 for 5 cycles in HOLD -> inst_valid stays 1, inst is unchanged, pc_en=0 and imem_req=0 throughout.
REQ-037 Flush during REQ: assert flush one cycle before ack with rdata=0xDEADBEEF -> inst_valid never rises for 0xDEADBEEF; the next LAUNCH samples the redirected pc.
REQ-038 Timeout: no ack for 15 cycles in REQ -> fetch_err=1, err_cause=10, imem_req=0. A subsequent flush -> fetch_err=0 and a new fetch begins.
REQ-039 Misaligned fetch: pc=0x00000006 in LAUNCH -> imem_req is never asserted, fetch_err=1, err_cause=01.
REQ-040 Async reset while in HOLD -> all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch FSM (LAUNCH/REQ/HOLD/ERR) with drop-on-flush and request timeout.
// Ports: pc_clk/reset (async, active-high); pc in; pc_en out to the PC register;
// imem_req/imem_addr/imem_ack/imem_rdata memory side; inst/inst_pc/inst_valid/decode_ready decode side;
// flush redirect in; fetch_err/err_cause sticky error out (01 misaligned, 10 timeout).
module inst_fetch #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        pc_clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        decode_ready,
  input  logic        flush,
  output logic        fetch_err,
  output logic [1:0]  err_cause
);
  typedef enum logic [1:0] {LAUNCH, REQ, HOLD, ERR} state_t;
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT_CYC - 1);
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic [1:0]  cause_q, cause_d;
  always_ff @(posedge pc_clk or posedge reset) begin
    if (reset) begin
      state_q   <= LAUNCH;
      addr_q    <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      cause_q   <= cause_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    cause_d   = cause_q;
    case (state_q)
      LAUNCH:
        if (pc[1:0] == 2'b00) begin
          addr_d    = pc;
          inst_pc_d = pc;
          cnt_d     = '0;
          state_d   = REQ;
        end else begin
          cause_d = 2'b01;
          state_d = ERR;
        end
      REQ:
        // a flush arriving in the ack cycle itself also poisons that data
        if (imem_ack) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = LAUNCH;
          end else begin
            inst_d  = imem_rdata;
            state_d = HOLD;
          end
        end else begin
          drop_d = drop_q | flush;
          if (cnt_q == CNT_LAST) begin
            cause_d = 2'b10;
            drop_d  = 1'b0;
            state_d = ERR;
          end else if (cnt_q != 4'hf) begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      HOLD:
        if (flush || decode_ready) state_d = LAUNCH;
      ERR:
        if (flush) begin
          cause_d = 2'b00;
          state_d = LAUNCH;
        end
      default: state_d = LAUNCH;
    endcase
  end
  assign pc_en      = ~reset & (((state_q == HOLD) & decode_ready & ~flush) | flush);
  assign imem_req   = state_q == REQ;
  assign imem_addr  = addr_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = state_q == HOLD;
  assign fetch_err  = state_q == ERR;
  assign err_cause  = cause_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with a small PC register model (+4 or redirect on pc_en).
module tb_inst_fetch;
  logic        pc_clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        decode_ready = 1'b0;
  logic        flush = 1'b0;
  logic        fetch_err;
  logic [1:0]  err_cause;
  logic [31:0] redirect = '0;
  int checks = 0;
  int failures = 0;
  inst_fetch #(.TIMEOUT_CYC(15)) dut (
    .pc_clk(pc_clk), .reset(reset), .pc(pc), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .decode_ready(decode_ready),
    .flush(flush), .fetch_err(fetch_err), .err_cause(err_cause)
  );
  always #5 pc_clk = ~pc_clk;
  always @(posedge pc_clk or posedge reset)
    if (reset) pc <= '0;
    else if (pc_en) pc <= flush ? redirect : pc + 32'd4;
  task automatic tick;
    @(posedge pc_clk);
    #2;
  endtask
  task automatic test_reset;
    flush = 1'b1;
    decode_ready = 1'b1;
    #12;
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL rst_pc_en got=%h exp=0", pc_en); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%h exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h/%h exp=0/0", inst, inst_pc); end
    checks++; if (inst_valid !== 1'b0 || fetch_err !== 1'b0 || err_cause !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b%b%b exp=0000", inst_valid, fetch_err, err_cause); end
    flush = 1'b0;
    decode_ready = 1'b0;
    @(negedge pc_clk);
    reset = 1'b0;
  endtask
  task automatic test_basic;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL basic_launch_req got=%h exp=0", imem_req); end
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL basic_req got=%h/%h exp=1/0", imem_req, imem_addr); end
    tick;
    imem_ack = 1'b1; imem_rdata = 32'h3C010001;
    tick;
    imem_ack = 1'b0; imem_rdata = '0;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h3C010001 || inst_pc !== 32'h0) begin failures++; $display("FAIL basic_hold got=%h/%h/%h exp=1/3c010001/0", inst_valid, inst, inst_pc); end
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL basic_no_ready_pc_en got=%h exp=0", pc_en); end
    decode_ready = 1'b1;
    #1;
    checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL basic_pc_en got=%h exp=1", pc_en); end
    tick;
    checks++; if (pc_en !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h4) begin failures++; $display("FAIL basic_advance got=%h/%h/%h exp=0/0/4", pc_en, inst_valid, pc); end
    decode_ready = 1'b0;
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL basic_next_req got=%h/%h exp=1/4", imem_req, imem_addr); end
  endtask
  task automatic test_backpressure;
    imem_ack = 1'b1; imem_rdata = 32'h11111111;
    tick;
    imem_ack = 1'b0; imem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h11111111 || inst_pc !== 32'h4 || pc_en !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got=%h/%h/%h/%h/%h exp=1/11111111/4/0/0", i, inst_valid, inst, inst_pc, pc_en, imem_req); end
      tick;
    end
    decode_ready = 1'b1;
    tick;
    decode_ready = 1'b0;
    checks++; if (pc !== 32'h8 || inst_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%h/%h exp=8/0", pc, inst_valid); end
  endtask
  task automatic test_flush_req;
    tick;
    tick;
    flush = 1'b1; redirect = 32'h100;
    #1;
    checks++; if (pc_en !== 1'b1 || imem_req !== 1'b1) begin failures++; $display("FAIL flreq_flush got=%h/%h exp=1/1", pc_en, imem_req); end
    tick;
    flush = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || pc !== 32'h100) begin failures++; $display("FAIL flreq_ack_cycle got=%h/%h/%h exp=1/8/100", imem_req, imem_addr, pc); end
    tick;
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b0 || inst === 32'hDEADBEEF) begin failures++; $display("FAIL flreq_dropped got=%h/%h exp=0/11111111", inst_valid, inst); end
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL flreq_redirect got=%h/%h exp=1/100", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h22222222;
    tick;
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h22222222 || inst_pc !== 32'h100) begin failures++; $display("FAIL flreq_refetch got=%h/%h/%h exp=1/22222222/100", inst_valid, inst, inst_pc); end
    decode_ready = 1'b1;
    tick;
    decode_ready = 1'b0;
  endtask
  task automatic test_timeout;
    tick;
    for (int i = 0; i < 15; i++) begin
      checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin failures++; $display("FAIL to_wait%0d got=%h/%h exp=1/0", i, imem_req, fetch_err); end
      tick;
    end
    checks++; if (fetch_err !== 1'b1 || err_cause !== 2'b10 || imem_req !== 1'b0) begin failures++; $display("FAIL to_err got=%h/%b/%h exp=1/10/0", fetch_err, err_cause, imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'h33333333;
    tick;
    imem_ack = 1'b0;
    checks++; if (fetch_err !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'h22222222) begin failures++; $display("FAIL to_late_ack got=%h/%h/%h exp=1/0/22222222", fetch_err, inst_valid, inst); end
    flush = 1'b1; redirect = 32'h200;
    #1;
    checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL to_flush_pc_en got=%h exp=1", pc_en); end
    tick;
    flush = 1'b0;
    checks++; if (fetch_err !== 1'b0 || err_cause !== 2'b00 || pc !== 32'h200) begin failures++; $display("FAIL to_clear got=%h/%b/%h exp=0/00/200", fetch_err, err_cause, pc); end
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL to_refetch got=%h/%h exp=1/200", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h44444444;
    tick;
    imem_ack = 1'b0;
    flush = 1'b1; decode_ready = 1'b1; redirect = 32'h6;
    tick;
    flush = 1'b0; decode_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0 || pc !== 32'h6) begin failures++; $display("FAIL hold_flush got=%h/%h exp=0/6", inst_valid, pc); end
  endtask
  task automatic test_misaligned;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mis_req%0d got=%h exp=0", i, imem_req); end
      tick;
    end
    checks++; if (fetch_err !== 1'b1 || err_cause !== 2'b01) begin failures++; $display("FAIL mis_err got=%h/%b exp=1/01", fetch_err, err_cause); end
    flush = 1'b1; redirect = 32'h300;
    tick;
    flush = 1'b0;
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || fetch_err !== 1'b0) begin failures++; $display("FAIL mis_recover got=%h/%h/%h exp=1/300/0", imem_req, imem_addr, fetch_err); end
  endtask
  task automatic test_async_reset;
    imem_ack = 1'b1; imem_rdata = 32'h55AA55AA;
    tick;
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h55AA55AA) begin failures++; $display("FAIL ar_hold got=%h/%h exp=1/55aa55aa", inst_valid, inst); end
    decode_ready = 1'b1;
    #1 reset = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || imem_addr !== 32'h0) begin failures++; $display("FAIL ar_regs got=%h/%h/%h/%h exp=0/0/0/0", inst_valid, inst, inst_pc, imem_addr); end
    checks++; if (pc_en !== 1'b0 || imem_req !== 1'b0 || fetch_err !== 1'b0 || err_cause !== 2'b00) begin failures++; $display("FAIL ar_ctrl got=%h/%h/%h/%b exp=0/0/0/00", pc_en, imem_req, fetch_err, err_cause); end
    decode_ready = 1'b0;
    @(negedge pc_clk);
    reset = 1'b0;
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL ar_restart got=%h/%h exp=1/0", imem_req, imem_addr); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_flush_req;
    test_timeout;
    test_misaligned;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
